// File: rtl/prng_req_arb_if.sv
// prng_req_arb_if: requester, seed and PRNG-core handshake bundle for prng_req_arb
// slave = arbiter side, master = requesters plus core side.
interface prng_req_arb_if #(
  parameter int NREQ = 4,
  parameter int DW = 32
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] err;
  logic [DW-1:0] rdata;
  logic [2:0] gnt_id;
  logic seed_load;
  logic [DW-1:0] seed_value;
  logic seed_busy;
  logic prng_step;
  logic prng_done;
  logic [DW-1:0] prng_out;
  logic prng_seed_we;
  logic [DW-1:0] prng_seed;
  modport slave (
    input req, seed_load, seed_value, prng_done, prng_out,
    output ack, err, rdata, gnt_id, seed_busy, prng_step, prng_seed_we, prng_seed
  );
  modport master (
    output req, seed_load, seed_value, prng_done, prng_out,
    input ack, err, rdata, gnt_id, seed_busy, prng_step, prng_seed_we, prng_seed
  );
endinterface

// File: rtl/prng_req_arb.sv
// prng_req_arb: round-robin sharing of one PRNG core among NREQ requesters with seed sequencing and step watchdog
// Ports: clk, rst (async, active-low), bus (prng_req_arb_if.slave):
//   req/ack/err/rdata/gnt_id to requesters, seed_load/seed_value/seed_busy for seeding,
//   prng_step/prng_done/prng_out/prng_seed_we/prng_seed to the core.
module prng_req_arb #(
  parameter int NREQ = 4,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  prng_req_arb_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, STEP, WAIT, DONE, SEED} state_t;
  state_t r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_gnt;
  logic [CW-1:0] r_cnt;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_seed;
  logic r_pend;
  logic r_step;
  logic r_seed_we;
  logic w_found;
  logic [2:0] w_pick;
  logic [IW-1:0] w_idx;
  logic [NREQ-1:0] w_gnt_oh;
  // Scan offsets from farthest to nearest so the nearest set req after ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick = r_ptr;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick = 3'(w_idx);
      end
    end
  end
  assign w_gnt_oh = NREQ'(1) << r_gnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr <= 3'(NREQ - 1);
      r_gnt <= '0;
      r_cnt <= '0;
      r_ack <= '0;
      r_err <= '0;
      r_rdata <= '0;
      r_seed <= '0;
      r_pend <= 1'b0;
      r_step <= 1'b0;
      r_seed_we <= 1'b0;
    end else begin
      // A load during SEED re-arms pend with the new value, so it is never lost.
      if (bus.seed_load) begin
        r_seed <= bus.seed_value;
        r_pend <= 1'b1;
      end else if (r_state == SEED) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (bus.seed_load || r_pend) begin
            r_seed_we <= 1'b1;
            r_state <= SEED;
          end else if (w_found) begin
            r_gnt <= w_pick;
            r_step <= 1'b1;
            r_state <= STEP;
          end
        end
        SEED: begin
          r_seed_we <= 1'b0;
          r_state <= IDLE;
        end
        STEP: begin
          r_step <= 1'b0;
          r_cnt <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.prng_done) begin
            r_rdata <= bus.prng_out;
            r_ack <= w_gnt_oh;
            r_state <= DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err <= w_gnt_oh;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_ack <= '0;
          r_err <= '0;
          r_ptr <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack = r_ack;
  assign bus.err = r_err;
  assign bus.rdata = r_rdata;
  assign bus.gnt_id = r_gnt;
  assign bus.seed_busy = r_pend;
  assign bus.prng_step = r_step;
  assign bus.prng_seed_we = r_seed_we;
  assign bus.prng_seed = r_seed;
endmodule

// File: tb/tb_prng_req_arb.sv
// tb_prng_req_arb: scenario tasks plus randomized traffic checked against a round-robin reference model
module tb_prng_req_arb;
  localparam int NREQ = 4;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  prng_req_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();
  prng_req_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  int m_ptr = NREQ - 1;
  logic inject = 1'b0;
  logic [DW-1:0] inj_word = '0;
  logic [DW-1:0] core_word = '0;
  logic seen = 1'b0;
  // Core model: mode 0 answers the cycle after a step with a fresh random word, mode 1 stays silent.
  always @(posedge clk) begin
    seen <= bus.prng_step;
    if (bus.prng_step) core_word <= $urandom;
  end
  assign bus.prng_done = (mode == 0 && seen) || inject;
  assign bus.prng_out = inject ? inj_word : core_word;
  // Reference arbitration: the set requester at the smallest circular distance after the last served one.
  function automatic int rr_pick(logic [NREQ-1:0] r, int ptr);
    int best, bestd, d;
    best = -1;
    bestd = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - ptr - 1 + 2 * NREQ) % NREQ;
      if (r[i] && d < bestd) begin
        bestd = d;
        best = i;
      end
    end
    return best;
  endfunction
  function automatic logic [NREQ-1:0] oh(int i);
    return NREQ'(1) << i;
  endfunction
  task automatic wait_step(input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.prng_step === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask
  task automatic wait_resp(input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if ((bus.ack | bus.err) !== '0) begin
        n = c;
        break;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    bus.seed_load = 1'b0;
    mode = 0;
    inject = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_ptr = NREQ - 1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    int n, g;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ack !== '0) begin miscompares++; $display("FAIL reset_ack got %h exp 0", bus.ack); end
    vectors++; if (bus.err !== '0) begin miscompares++; $display("FAIL reset_err got %h exp 0", bus.err); end
    vectors++; if (bus.rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
    vectors++; if (bus.gnt_id !== '0) begin miscompares++; $display("FAIL reset_gnt_id got %0d exp 0", bus.gnt_id); end
    vectors++; if (bus.seed_busy !== 1'b0) begin miscompares++; $display("FAIL reset_seed_busy got %b exp 0", bus.seed_busy); end
    vectors++; if (bus.prng_step !== 1'b0) begin miscompares++; $display("FAIL reset_step got %b exp 0", bus.prng_step); end
    vectors++; if (bus.prng_seed_we !== 1'b0) begin miscompares++; $display("FAIL reset_seed_we got %b exp 0", bus.prng_seed_we); end
    vectors++; if (bus.prng_seed !== '0) begin miscompares++; $display("FAIL reset_prng_seed got %h exp 0", bus.prng_seed); end
    rst = 1'b1;
    m_ptr = NREQ - 1;
    @(negedge clk);
    bus.req = 4'b0100;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL first_step_latency got %0d exp 1", n); end
    wait_resp(8, n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL first_ack_after_step got %0d exp 2", n); end
    vectors++; if (bus.ack !== oh(g) || bus.err !== '0) begin miscompares++; $display("FAIL first_ack got ack %b err %b exp ack %b", bus.ack, bus.err, oh(g)); end
    vectors++; if (bus.gnt_id !== 3'(g)) begin miscompares++; $display("FAIL first_gnt_id got %0d exp %0d", bus.gnt_id, g); end
    vectors++; if (bus.rdata !== core_word) begin miscompares++; $display("FAIL first_rdata got %h exp %h", bus.rdata, core_word); end
    m_ptr = g;
    bus.req = '0;
    @(negedge clk);
    vectors++; if (bus.ack !== '0) begin miscompares++; $display("FAIL ack_one_cycle got %b exp 0", bus.ack); end
  endtask
  task automatic test_fairness();
    int n, g;
    do_reset();
    bus.req = '1;
    for (int t = 0; t < 2 * NREQ; t++) begin
      g = rr_pick(bus.req, m_ptr);
      wait_resp(12, n);
      vectors++; if (n !== ((t == 0) ? 3 : 4)) begin miscompares++; $display("FAIL fair_latency t=%0d got %0d exp %0d", t, n, (t == 0) ? 3 : 4); end
      vectors++; if (bus.ack !== oh(g) || bus.err !== '0) begin miscompares++; $display("FAIL fair_ack t=%0d got %b exp %b", t, bus.ack, oh(g)); end
      vectors++; if (bus.gnt_id !== 3'(g)) begin miscompares++; $display("FAIL fair_gnt t=%0d got %0d exp %0d", t, bus.gnt_id, g); end
      m_ptr = g;
    end
    bus.req = '0;
  endtask
  task automatic test_seed_priority();
    int n, g, first;
    logic [DW-1:0] got_seed;
    @(negedge clk);
    bus.req = 4'b0010;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL sp_step got %0d exp 1", n); end
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed_value = 32'hdeadbeef;
    bus.req = 4'b1010;
    @(negedge clk);
    bus.seed_load = 1'b0;
    vectors++; if (bus.ack !== oh(g) || bus.rdata !== core_word) begin miscompares++; $display("FAIL sp_ack got %b/%h exp %b/%h", bus.ack, bus.rdata, oh(g), core_word); end
    vectors++; if (bus.seed_busy !== 1'b1) begin miscompares++; $display("FAIL sp_busy got %b exp 1", bus.seed_busy); end
    m_ptr = g;
    bus.req = 4'b1000;
    first = 0;
    got_seed = '0;
    for (int c = 0; c < 6 && first == 0; c++) begin
      @(negedge clk);
      if (bus.prng_seed_we === 1'b1) begin first = 1; got_seed = bus.prng_seed; end
      else if (bus.prng_step === 1'b1) first = 2;
    end
    vectors++; if (first !== 1) begin miscompares++; $display("FAIL sp_seed_first got %0d exp 1", first); end
    vectors++; if (got_seed !== 32'hdeadbeef) begin miscompares++; $display("FAIL sp_seed_val got %h exp deadbeef", got_seed); end
    @(negedge clk);
    vectors++; if (bus.seed_busy !== 1'b0) begin miscompares++; $display("FAIL sp_busy_fall got %b exp 0", bus.seed_busy); end
    g = rr_pick(bus.req, m_ptr);
    wait_resp(10, n);
    vectors++; if (n < 0 || bus.ack !== oh(g)) begin miscompares++; $display("FAIL sp_next_ack got %b exp %b", bus.ack, oh(g)); end
    m_ptr = g;
    bus.req = '0;
  endtask
  task automatic test_seed_overwrite();
    int n, g, cnt;
    logic [DW-1:0] got_seed;
    mode = 1;
    @(negedge clk);
    bus.req = 4'b0001;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed_value = 32'h0;
    @(negedge clk);
    bus.seed_value = 32'h12345678;
    @(negedge clk);
    bus.seed_load = 1'b0;
    inj_word = $urandom;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    vectors++; if (bus.ack !== oh(g) || bus.rdata !== inj_word) begin miscompares++; $display("FAIL ow_ack got %b/%h exp %b/%h", bus.ack, bus.rdata, oh(g), inj_word); end
    m_ptr = g;
    bus.req = '0;
    cnt = 0;
    got_seed = '0;
    repeat (8) begin
      @(negedge clk);
      if (bus.prng_seed_we === 1'b1) begin cnt++; got_seed = bus.prng_seed; end
    end
    vectors++; if (cnt !== 1) begin miscompares++; $display("FAIL ow_we_count got %0d exp 1", cnt); end
    vectors++; if (got_seed !== 32'h12345678) begin miscompares++; $display("FAIL ow_seed_val got %h exp 12345678", got_seed); end
    mode = 0;
  endtask
  task automatic test_timeout();
    int n, g, extra;
    logic [DW-1:0] saved;
    mode = 1;
    saved = bus.rdata;
    @(negedge clk);
    bus.req = 4'b0001;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    wait_resp(TIMEOUT + 6, n);
    vectors++; if (n !== TIMEOUT + 1) begin miscompares++; $display("FAIL to_latency got %0d exp %0d", n, TIMEOUT + 1); end
    vectors++; if (bus.err !== oh(g) || bus.ack !== '0) begin miscompares++; $display("FAIL to_err got err %b ack %b exp err %b", bus.err, bus.ack, oh(g)); end
    vectors++; if (bus.rdata !== saved) begin miscompares++; $display("FAIL to_rdata got %h exp %h", bus.rdata, saved); end
    m_ptr = g;
    bus.req = '0;
    @(negedge clk);
    inj_word = $urandom;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if ((bus.ack | bus.err) !== '0) extra++;
    end
    vectors++; if (extra !== 0 || bus.rdata !== saved) begin miscompares++; $display("FAIL to_late_done got %0d responses rdata %h exp 0 responses %h", extra, bus.rdata, saved); end
    mode = 0;
    bus.req = 4'b0100;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL to_idle_step got %0d exp 1", n); end
    wait_resp(8, n);
    vectors++; if (n !== 2 || bus.ack !== oh(g)) begin miscompares++; $display("FAIL to_next_ack got %b at %0d exp %b at 2", bus.ack, n, oh(g)); end
    m_ptr = g;
    bus.req = '0;
  endtask
  task automatic test_async_reset();
    int n, g, extra;
    mode = 1;
    @(negedge clk);
    bus.req = 4'b0010;
    wait_step(4, n);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.gnt_id !== '0 || bus.rdata !== '0 || bus.prng_seed !== '0) begin miscompares++; $display("FAIL ar_regs got gnt %0d rdata %h seed %h exp 0", bus.gnt_id, bus.rdata, bus.prng_seed); end
    vectors++; if ({bus.ack, bus.err, bus.prng_step, bus.prng_seed_we, bus.seed_busy} !== '0) begin miscompares++; $display("FAIL ar_strobes got %b exp 0", {bus.ack, bus.err, bus.prng_step, bus.prng_seed_we, bus.seed_busy}); end
    bus.req = '0;
    mode = 0;
    @(negedge clk);
    rst = 1'b1;
    m_ptr = NREQ - 1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if ((bus.ack | bus.err) !== '0 || bus.prng_step === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ar_no_ack got %0d events exp 0", extra); end
    bus.req = 4'b0001;
    g = rr_pick(bus.req, m_ptr);
    wait_step(4, n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL ar_step got %0d exp 1", n); end
    wait_resp(8, n);
    vectors++; if (n !== 2 || bus.ack !== oh(g) || bus.rdata !== core_word) begin miscompares++; $display("FAIL ar_ack got %b/%h at %0d exp %b/%h at 2", bus.ack, bus.rdata, n, oh(g), core_word); end
    m_ptr = g;
    bus.req = '0;
  endtask
  task automatic test_random();
    int n, g, nseed, nstep;
    logic ds;
    logic [NREQ-1:0] r;
    logic [DW-1:0] sv, got_seed;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      ds = ($urandom_range(0, 3) == 0);
      sv = $urandom;
      bus.req = r;
      bus.seed_load = ds;
      bus.seed_value = sv;
      g = rr_pick(r, m_ptr);
      n = -1;
      nseed = 0;
      nstep = 0;
      got_seed = '0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        bus.seed_load = 1'b0;
        if (bus.prng_seed_we === 1'b1) begin nseed++; got_seed = bus.prng_seed; end
        if (bus.prng_step === 1'b1) nstep++;
        if ((bus.ack | bus.err) !== '0) begin n = c; break; end
      end
      vectors++; if (n !== (ds ? 5 : 3)) begin miscompares++; $display("FAIL rnd_latency t=%0d got %0d exp %0d", t, n, ds ? 5 : 3); end
      vectors++; if (bus.ack !== oh(g) || bus.err !== '0 || bus.gnt_id !== 3'(g)) begin miscompares++; $display("FAIL rnd_grant t=%0d req %b got ack %b err %b gnt %0d exp ack %b gnt %0d", t, r, bus.ack, bus.err, bus.gnt_id, oh(g), g); end
      vectors++; if (bus.rdata !== core_word || nstep !== 1) begin miscompares++; $display("FAIL rnd_data t=%0d got %h steps %0d exp %h steps 1", t, bus.rdata, nstep, core_word); end
      if (ds) begin
        vectors++; if (nseed !== 1 || got_seed !== sv) begin miscompares++; $display("FAIL rnd_seed t=%0d got %0d writes %h exp 1 write %h", t, nseed, got_seed, sv); end
      end
      m_ptr = g;
      bus.req = '0;
    end
  endtask
  initial begin
    bus.req = '0;
    bus.seed_load = 1'b0;
    bus.seed_value = '0;
    test_reset();
    test_fairness();
    test_seed_priority();
    test_seed_overwrite();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
